// File: rtl/br_pkg.sv
// Shared definitions for the execute-stage branch resolution block.
// - br_type encodings as delivered by decode
// - controller state encoding
// - default length of the front-end flush window
// - helper that tells which op types count as control transfers for statistics
package br_pkg;

  localparam logic [2:0] BR_EQ   = 3'b000;
  localparam logic [2:0] BR_NE   = 3'b001;
  localparam logic [2:0] BR_NONE = 3'b010;
  localparam logic [2:0] BR_JMP  = 3'b011;
  localparam logic [2:0] BR_LT   = 3'b100;
  localparam logic [2:0] BR_GE   = 3'b101;
  localparam logic [2:0] BR_LTU  = 3'b110;
  localparam logic [2:0] BR_GEU  = 3'b111;

  localparam int FLUSH_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  // Every op except the "none" encoding is a control transfer.
  function automatic logic is_ctrl_xfer(input logic [2:0] br_type);
    return br_type != BR_NONE;
  endfunction

endpackage

// File: rtl/br_compare.sv
// Combinational branch condition evaluator.
// Ports:
//   br_type  in  3     op encoding (see br_pkg)
//   a, b     in  XLEN  rs1 / rs2 operands
//   taken    out 1     condition holds
module br_compare
  import br_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   eq;
  logic                   lt_s;
  logic                   lt_u;

  assign a_s  = a;
  assign b_s  = b;
  assign eq   = (a == b);
  assign lt_s = (a_s < b_s);
  assign lt_u = (a < b);

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_EQ:   taken = eq;
      BR_NE:   taken = !eq;
      BR_NONE: taken = 1'b0;
      BR_JMP:  taken = 1'b1;
      BR_LT:   taken = lt_s;
      BR_GE:   taken = !lt_s;
      BR_LTU:  taken = lt_u;
      BR_GEU:  taken = !lt_u;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch/jump resolution controller (static predict-not-taken).
// An accepted op is registered for one stage; in the following RESOLVE cycle
// the condition, target and link value are presented. A taken, aligned op
// pulses redirect and then holds flush for FLUSH_CYCLES cycles, during which
// no new op is accepted. A taken, misaligned target raises misalign_err
// instead of redirecting.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      decode handshake
//   in_br_type, in_is_jalr   op kind
//   in_pc, in_a, in_b, in_imm op operands
//   res_valid, res_taken, res_link          resolve-cycle results
//   redirect, redirect_pc, flush            front-end control
//   misalign_err                            taken target not word aligned
//   stat_clr, stat_branches, stat_taken     statistics
module branch_resolve_ctrl
  import br_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_br_type,
  input  logic            in_is_jalr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_imm,
  output logic            res_valid,
  output logic            res_taken,
  output logic [XLEN-1:0] res_link,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            misalign_err,
  input  logic            stat_clr,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e     state, state_nxt;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic       accept;

  logic [2:0]      br_type_p1;
  logic            is_jalr_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] a_p1;
  logic [XLEN-1:0] b_p1;
  logic [XLEN-1:0] imm_p1;

  logic            vld_p1;
  logic            taken_p1;
  logic [XLEN-1:0] jalr_sum_p1;
  logic [XLEN-1:0] target_p1;
  logic            aligned_p1;
  logic            redirect_p1;

  // ---- stage p0 -> p1: accept and register the op ----
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      br_type_p1 <= in_br_type;
      is_jalr_p1 <= in_is_jalr;
      pc_p1      <= in_pc;
      a_p1       <= in_a;
      b_p1       <= in_b;
      imm_p1     <= in_imm;
    end
  end

  // ---- stage p1: resolve condition, target and link ----
  br_compare #(.XLEN(XLEN)) u_cmp (
    .br_type (br_type_p1),
    .a       (a_p1),
    .b       (b_p1),
    .taken   (taken_p1)
  );

  // Pulse outputs are suppressed in a reset cycle so an op caught
  // mid-resolve never produces a redirect.
  assign vld_p1      = (state == RESOLVE) && !rst;
  assign jalr_sum_p1 = a_p1 + imm_p1;
  assign target_p1   = (br_type_p1 == BR_JMP && is_jalr_p1)
                       ? {jalr_sum_p1[XLEN-1:1], 1'b0}
                       : pc_p1 + imm_p1;
  assign aligned_p1  = (target_p1[1:0] == 2'b00);
  assign redirect_p1 = vld_p1 && taken_p1 && aligned_p1;

  assign res_valid    = vld_p1;
  assign res_taken    = vld_p1 && taken_p1;
  assign res_link     = vld_p1 ? pc_p1 + XLEN'(4) : '0;
  assign redirect     = redirect_p1;
  assign redirect_pc  = redirect_p1 ? target_p1 : '0;
  assign misalign_err = vld_p1 && taken_p1 && !aligned_p1;
  assign flush        = (state == FLUSH);

  // ---- control FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    in_ready      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (accept) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (redirect_p1) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_LOAD;
        end else begin
          in_ready  = !rst;
          state_nxt = accept ? RESOLVE : IDLE;
        end
      end
      FLUSH: begin
        // Leaving on a count of 1 makes the window exactly FLUSH_CYCLES long.
        flush_cnt_nxt = flush_cnt - 4'd1;
        if (flush_cnt <= 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- statistics ----
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (vld_p1) begin
      stat_branches <= stat_branches + 32'(is_ctrl_xfer(br_type_p1));
      stat_taken    <= stat_taken + 32'(taken_p1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: the driver pushes the expected
// result of each accepted op; a negedge monitor pops and compares.
module tb_branch_resolve_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_br_type = 3'd0;
  logic        in_is_jalr = 1'b0;
  logic [31:0] in_pc = '0, in_a = '0, in_b = '0, in_imm = '0;
  logic        res_valid, res_taken, redirect, flush, misalign_err;
  logic [31:0] res_link, redirect_pc;
  logic        stat_clr = 1'b0;
  logic [31:0] stat_branches, stat_taken;

  branch_resolve_ctrl #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_br_type(in_br_type), .in_is_jalr(in_is_jalr), .in_pc(in_pc),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
    .res_valid(res_valid), .res_taken(res_taken), .res_link(res_link),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .misalign_err(misalign_err), .stat_clr(stat_clr),
    .stat_branches(stat_branches), .stat_taken(stat_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        taken;
    logic        br;
    logic        redir;
    logic        mis;
    logic [31:0] tgt;
    logic [31:0] link;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned m_br = 0, m_tk = 0;
  int          flush_rem = 0;
  logic        prev_rst = 1'b0;
  exp_t        mon_e;
  logic        mon_fl, mon_redir;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Reference: results straight from the ISA rules.
  function automatic exp_t model(input logic [2:0] t, input logic j,
                                 input logic [31:0] pc, a, b, imm);
    exp_t e;
    case (t)
      3'd0: e.taken = (a == b);
      3'd1: e.taken = (a != b);
      3'd2: e.taken = 1'b0;
      3'd3: e.taken = 1'b1;
      3'd4: e.taken = ($signed(a) < $signed(b));
      3'd5: e.taken = ($signed(a) >= $signed(b));
      3'd6: e.taken = (a < b);
      default: e.taken = (a >= b);
    endcase
    if (t == 3'd3 && j) e.tgt = (a + imm) & 32'hFFFF_FFFE;
    else                e.tgt = pc + imm;
    e.link  = pc + 32'd4;
    e.mis   = e.taken && ((e.tgt % 4) != 0);
    e.redir = e.taken && !e.mis;
    e.br    = (t != 3'd2);
    e.cyc   = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: everything of a cycle (inputs and outputs) is stable at negedge.
  always @(negedge clk) begin
    chk("stat_branches", stat_branches, m_br);
    chk("stat_taken", stat_taken, m_tk);
    if (rst) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_redirect", redirect, 0);
      chk("rst_misalign", misalign_err, 0);
      chk("rst_in_ready", in_ready, 0);
      if (prev_rst) chk("rst_flush", flush, 0);
      m_br = 0; m_tk = 0; flush_rem = 0;
      q.delete();
    end else begin
      mon_fl    = (flush_rem > 0);
      mon_redir = 1'b0;
      chk("flush", flush, mon_fl);
      if (!res_valid && q.size() > 0 && q[0].cyc + 1 <= cyc) begin
        chk("res_valid_missing", 0, 1);
        void'(q.pop_front());
      end
      if (res_valid) begin
        if (q.size() == 0) chk("res_valid_spurious", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("latency", cyc, mon_e.cyc + 1);
          chk("res_taken", res_taken, mon_e.taken);
          chk("res_link", res_link, mon_e.link);
          chk("redirect", redirect, mon_e.redir);
          chk("misalign_err", misalign_err, mon_e.mis);
          if (mon_e.redir) chk("redirect_pc", redirect_pc, mon_e.tgt);
          mon_redir = mon_e.redir;
          m_br += 32'(mon_e.br);
          m_tk += 32'(mon_e.taken);
        end
      end else begin
        chk("idle_redirect", redirect, 0);
        chk("idle_misalign", misalign_err, 0);
      end
      chk("in_ready", in_ready, !(mon_fl || mon_redir));
      if (stat_clr) begin m_br = 0; m_tk = 0; end
      if (mon_fl) flush_rem--;
      if (mon_redir) flush_rem = FC;
    end
    prev_rst = rst;
  end

  // Offer an op (driven just after a posedge) and wait until it is accepted.
  task automatic drive_op(input logic [2:0] t, input logic j,
                          input logic [31:0] pc, a, b, imm);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; in_br_type = t; in_is_jalr = j;
    in_pc = pc; in_a = a; in_b = b; in_imm = imm; stat_clr = 1'b0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      e = model(t, j, pc, a, b, imm);
      e.cyc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic idle(input logic clr);
    @(posedge clk); #1;
    in_valid = 1'b0; stat_clr = clr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  t;
    logic [31:0] a, b, pc, imm;

    // Reset held 3 cycles with an op offered.
    in_valid = 1'b1; in_br_type = 3'd3; in_pc = 32'h80;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", in_ready, 1);
    chk("post_reset_res_valid", res_valid, 0);

    // beq not-taken streaming.
    for (int i = 0; i < 4; i++) drive_op(3'd0, 1'b0, 32'h40 + 32'(4 * i), 32'd5, 32'd6, 32'h10);
    idle(0);
    @(posedge clk); @(negedge clk);
    chk("stream_branches", stat_branches, 32'd4);
    chk("stream_taken", stat_taken, 32'd0);

    // Signed compare taken, then flush window.
    drive_op(3'd4, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    idle(0);
    @(negedge clk);
    chk("blt_redirect", redirect, 1);
    chk("blt_redirect_pc", redirect_pc, 32'h120);
    chk("blt_ready0", in_ready, 0);
    @(negedge clk);
    chk("blt_flush1", flush, 1); chk("blt_ready1", in_ready, 0);
    @(negedge clk);
    chk("blt_flush2", flush, 1); chk("blt_ready2", in_ready, 0);
    @(negedge clk);
    chk("blt_flush_end", flush, 0); chk("blt_ready_back", in_ready, 1);

    // Unsigned compare on the same operands: not taken.
    drive_op(3'd6, 1'b0, 32'h104, 32'hFFFF_FFFF, 32'd1, 32'h20);
    idle(0);
    @(negedge clk);
    chk("bltu_taken", res_taken, 0);
    chk("bltu_redirect", redirect, 0);

    // jalr to a misaligned target.
    drive_op(3'd3, 1'b1, 32'h300, 32'h1003, 32'd0, 32'd0);
    idle(0);
    @(negedge clk);
    chk("jalr_misalign", misalign_err, 1);
    chk("jalr_redirect", redirect, 0);
    chk("jalr_taken", res_taken, 1);
    chk("jalr_link", res_link, 32'h304);
    @(negedge clk);
    chk("jalr_no_flush", flush, 0);

    // jal wrapping around the address space.
    drive_op(3'd3, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8);
    idle(0);
    @(negedge clk);
    chk("jal_wrap_pc", redirect_pc, 32'h4);
    chk("jal_wrap_link", res_link, 32'h0);

    // Reset in the first flush cycle.
    drive_op(3'd3, 1'b0, 32'h200, 32'd0, 32'd0, 32'h40);
    idle(0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midflush_flush", flush, 0);
    chk("midflush_branches", stat_branches, 0);
    chk("midflush_ready", in_ready, 1);
    drive_op(3'd1, 1'b0, 32'h500, 32'd1, 32'd2, 32'h8);
    idle(0);
    @(negedge clk);
    chk("after_rst_valid", res_valid, 1);
    chk("after_rst_redirect_pc", redirect_pc, 32'h508);

    // stat_clr coinciding with a taken resolve.
    drive_op(3'd3, 1'b0, 32'h600, 32'd0, 32'd0, 32'h10);
    idle(1);
    @(posedge clk); #1; stat_clr = 1'b0;
    @(negedge clk);
    chk("clr_branches", stat_branches, 0);
    chk("clr_taken", stat_taken, 0);

    // Randomized ops with gaps and occasional statistics clears.
    for (int i = 0; i < 300; i++) begin
      t = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]};
      pc = {$urandom_range(0, 32'hFFFF), 2'b00} | (($urandom_range(0, 9) == 0) ? 32'hFFFF_0000 : 32'h0);
      imm = ($urandom_range(0, 4) == 0) ? $urandom : (32'($signed(12'($urandom))) & 32'hFFFF_FFFC);
      drive_op(t, 1'($urandom), pc, a, b, imm);
      if ($urandom_range(0, 2) == 0) begin
        idle(1'($urandom_range(0, 7) == 0));
        repeat ($urandom_range(0, 2)) idle(0);
      end
    end
    idle(0);
    repeat (FC + 4) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences branch/jump resolution in the RV32I execute stage.
- Accepts decoded control-transfer ops from decode through a valid/ready handshake and registers them for one stage.
- Evaluates the condition, computes the target and link value, and issues a PC redirect plus a timed front-end flush.
- Static predict-not-taken: every taken op redirects. Also keeps branch/taken statistics counters.

Parameters:
- FLUSH_CYCLES, 2, cycles flush is held after a redirect (legal 1..15)
- XLEN, 32, datapath width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decode offers an op
- in_ready  out  1  block can accept an op this cycle
- in_br_type  in  3  000 beq, 001 bne, 010 none, 011 jump, 100 blt, 101 bge, 110 bltu, 111 bgeu
- in_is_jalr  in  1  target base is rs1, not pc (meaningful only with 011)
- in_pc  in  XLEN  pc of the op
- in_a  in  XLEN  rs1 value
- in_b  in  XLEN  rs2 value
- in_imm  in  XLEN  sign-extended offset
- res_valid  out  1  one-cycle pulse: result fields valid
- res_taken  out  1  condition resolved taken
- res_link  out  XLEN  in_pc+4, for jal/jalr writeback
- redirect  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  XLEN  target
- flush  out  1  kill IF/ID contents
- misalign_err  out  1  one-cycle pulse: taken target not 4-byte aligned
- stat_clr  in  1  clear statistics
- stat_branches  out  32  resolved ops with br_type != 010
- stat_taken  out  32  taken ops

Behaviour:
- Reset values: all outputs 0; in_ready 1 from the first cycle after reset; state IDLE; counters 0.
- rst takes priority over every other input. An op offered in the reset cycle is dropped.
- Accept occurs when in_valid && in_ready. Fields are latched on that edge.
- Latency: result appears exactly 1 cycle after accept (RESOLVE cycle). res_valid, redirect and misalign_err are high only in that cycle.
- Condition rules:
  - beq/bne: equality.
  - blt/bge: two's-complement signed compare.
  - bltu/bgeu: unsigned compare.
  - 010: never taken.
  - 011: always taken.
- Target rules (all sums wrap modulo 2^XLEN):
  - pc+imm for branches and jal.
  - (a+imm) with bit0 cleared for jalr.
  - res_link = pc+4.
- Misaligned target:
  - Taken with target[1:0] != 0: misalign_err=1, redirect=0, no flush, res_taken=1.
  - Not-taken ops never raise misalign_err.
- States:
  - IDLE: in_ready=1. Accept -> RESOLVE.
  - RESOLVE:
    - Taken and aligned: redirect=1, in_ready=0, load flush counter with FLUSH_CYCLES -> FLUSH.
    - Otherwise: in_ready=1. Accept -> RESOLVE (back-to-back, one op per cycle); no accept -> IDLE.
  - FLUSH: flush=1, in_ready=0, counter decrements each cycle. Leave to IDLE when the counter reaches 1, so flush is high for exactly FLUSH_CYCLES cycles starting the cycle after redirect.
- in_valid during FLUSH is ignored. Decode must hold its op; no op is lost or duplicated.
- Statistics:
  - Updated in RESOLVE.
  - stat_clr has priority over the increment in the same cycle.
  - Counters wrap at 2^32.
- Reset mid-FLUSH or mid-RESOLVE aborts immediately: flush drops next cycle, and no redirect pulse is emitted for the pending op.

Decomposition:
- Package br_pkg:
  - br_type localparams: BR_EQ, BR_NE, BR_NONE, BR_JMP, BR_LT, BR_GE, BR_LTU, BR_GEU.
  - State encoding: IDLE, RESOLVE, FLUSH.
  - Default FLUSH_CYCLES.
- One combinational sub-module br_compare(br_type, a, b) -> taken, instanced on the registered operands. The controller holds the FSM, the target adder and the counters.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> all outputs 0 and no accept; in_ready=1 on the cycle after rst falls.
- beq not-taken streaming: four back-to-back ops with a=5, b=6 -> res_valid on 4 consecutive cycles, res_taken=0, no redirect, in_ready stays 1; stat_branches=4, stat_taken=0.
- Signed vs unsigned compare: a=0xFFFFFFFF, b=1:
  - blt -> taken, redirect_pc=pc+imm (pc=0x100, imm=0x20 -> 0x120).
  - bltu -> not taken.
  - Check the flush window: flush high exactly 2 cycles after the redirect, in_ready low for 3 cycles.
- jalr: a=0x1003, imm=0 -> target 0x1002; misalign_err=1, redirect=0, flush=0, res_link=pc+4.
- jal at pc=0xFFFFFFFC, imm=8 -> redirect_pc=0x00000004 (wrap); res_link=0x00000000.
- Reset mid-flush: assert rst in the first FLUSH cycle -> flush=0 on the next cycle, counters cleared, next op accepted normally. Also assert stat_clr together with a taken resolve -> counters read 0.
